byte_stream_packer: RTL and testbench

Packs a byte-serial packet stream into DATA_BYTES-wide beats carrying valid, sop, eop and byte-enable sideband. It sits directly upstream of payload_aligner and drives its iValid/iPacket/iSop/iEop/iByte_enable inputs one-to-one. Byte 0 of a packet always lands in lane 0, the least-significant byte of the output word.

---
 rtl/byte_stream_packer_pkg.sv | 14 +
 rtl/byte_stream_packer_if.sv | 24 ++
 rtl/byte_stream_packer.sv | 77 +++++++
 tb/tb_byte_stream_packer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/byte_stream_packer_pkg.sv
// byte_stream_packer_pkg: shared beat geometry, lane-index width helper and beat struct
package byte_stream_packer_pkg;
   localparam int DATA_BYTES = 8;
   localparam int LEN_W = 16;
   function automatic int lane_w(input int n);
      return $clog2(n);
   endfunction
   typedef struct packed {
      logic [8*DATA_BYTES-1:0] data;
      logic                    sop;
      logic                    eop;
      logic [DATA_BYTES-1:0]   byte_enable;
   } beat_t;
endpackage

// File: rtl/byte_stream_packer_if.sv
// byte_stream_packer_if: byte-side handshake in, beat-side sideband out
// master: byte producer / beat consumer; slave: the packer.
// oLength exists only when BYTE_STREAM_PACKER_LEN_EN is defined.
interface byte_stream_packer_if
   import byte_stream_packer_pkg::*;
;
   logic                    iValid;
   logic [7:0]              iByte;
   logic                    iLast;
   logic                    oReady;
   logic                    oValid;
   logic [8*DATA_BYTES-1:0] oPacket;
   logic                    oSop;
   logic                    oEop;
   logic [DATA_BYTES-1:0]   oByte_enable;
`ifdef BYTE_STREAM_PACKER_LEN_EN
   logic [LEN_W-1:0]        oLength;
   modport master (output iValid, iByte, iLast, input oReady, oValid, oPacket, oSop, oEop, oByte_enable, oLength);
   modport slave  (input iValid, iByte, iLast, output oReady, oValid, oPacket, oSop, oEop, oByte_enable, oLength);
`else
   modport master (output iValid, iByte, iLast, input oReady, oValid, oPacket, oSop, oEop, oByte_enable);
   modport slave  (input iValid, iByte, iLast, output oReady, oValid, oPacket, oSop, oEop, oByte_enable);
`endif
endinterface

// File: rtl/byte_stream_packer.sv
// byte_stream_packer: packs a byte-serial packet stream into DATA_BYTES-wide beats
// Ports: iClk (rising edge), iReset (async, active-high), bus (slave modport):
//   iValid/iByte/iLast in, oReady out; oValid/oPacket/oSop/oEop/oByte_enable out.
// Optional BYTE_STREAM_PACKER_LEN_EN adds a saturating byte counter driving oLength.
module byte_stream_packer
   import byte_stream_packer_pkg::*;
(
   input logic                iClk,
   input logic                iReset,
   byte_stream_packer_if.slave bus
);
   localparam int LW = lane_w(DATA_BYTES);
   logic [DATA_BYTES-1:0][7:0] build_q, build_d, merged;
   logic [LW-1:0] lane_q, lane_d;
   logic first_q, first_d, valid_q, valid_d, ready_q;
   beat_t beat_q, beat_d;
   logic acc, done;
   always_comb begin
      acc = bus.iValid && ready_q;
      done = acc && (bus.iLast || lane_q == LW'(DATA_BYTES - 1));
      merged = build_q;
      merged[lane_q] = bus.iByte;
      beat_d = beat_q;
      if (done) begin
         // lanes above `lane` are still zero from the last clear, so eop padding is free
         beat_d.data = merged;
         beat_d.sop = first_q;
         beat_d.eop = bus.iLast;
         for (int i = 0; i < DATA_BYTES; i++) beat_d.byte_enable[i] = i <= int'(lane_q);
      end
      build_d = done ? '0 : acc ? merged : build_q;
      lane_d = done ? '0 : acc ? lane_q + 1'b1 : lane_q;
      first_d = done ? bus.iLast : first_q;
      valid_d = done;
   end
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         build_q <= '0;
         lane_q <= '0;
         first_q <= 1'b1;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
         beat_q <= '0;
      end else begin
         build_q <= build_d;
         lane_q <= lane_d;
         first_q <= first_d;
         valid_q <= valid_d;
         ready_q <= 1'b1;
         beat_q <= beat_d;
      end
   end
   assign bus.oReady = ready_q;
   assign bus.oValid = valid_q;
   assign bus.oPacket = beat_q.data;
   assign bus.oSop = beat_q.sop;
   assign bus.oEop = beat_q.eop;
   assign bus.oByte_enable = beat_q.byte_enable;
`ifdef BYTE_STREAM_PACKER_LEN_EN
   logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc, length_q, length_d;
   always_comb begin
      cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
      cnt_d = acc ? (bus.iLast ? '0 : cnt_inc) : cnt_q;
      length_d = (acc && bus.iLast) ? cnt_inc : length_q;
   end
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         cnt_q <= '0;
         length_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         length_q <= length_d;
      end
   end
   assign bus.oLength = length_q;
`endif
endmodule

// File: tb/tb_byte_stream_packer.sv
// tb_byte_stream_packer: directed self-checking bench for byte_stream_packer
module tb_byte_stream_packer;
   logic iClk = 1'b0;
   logic iReset = 1'b1;
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_cyc = 0;
   byte_stream_packer_if bus ();
   byte_stream_packer dut (.iClk(iClk), .iReset(iReset), .bus(bus));
   always #5 iClk = ~iClk;
   always @(posedge iClk) cyc <= cyc + 1;
   typedef struct {
      logic [63:0] d;
      logic        s;
      logic        e;
      logic [7:0]  be;
      int          c;
      logic [15:0] len;
   } cap_t;
   cap_t q[$];
   always @(negedge iClk) begin
      if (bus.oValid === 1'b1) begin
`ifdef BYTE_STREAM_PACKER_LEN_EN
         q.push_back('{bus.oPacket, bus.oSop, bus.oEop, bus.oByte_enable, cyc, bus.oLength});
`else
         q.push_back('{bus.oPacket, bus.oSop, bus.oEop, bus.oByte_enable, cyc, 16'd0});
`endif
      end
   end
   task automatic drive(input logic [7:0] b, input logic l);
      @(negedge iClk);
      bus.iValid = 1'b1;
      bus.iByte = b;
      bus.iLast = l;
      last_cyc = cyc;
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge iClk);
         bus.iValid = 1'b0;
         bus.iLast = 1'b0;
         bus.iByte = 8'hxx;
      end
   endtask
   function automatic logic [7:0] sb(input int i);
      return 8'(i * 37 + 11);
   endfunction
   task automatic test_reset;
      @(negedge iClk);
      @(negedge iClk);
      checks += 6;
      if (bus.oValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.oValid); end
      if (bus.oSop !== 1'b0) begin errors++; $display("FAIL reset_sop got=%b want=0", bus.oSop); end
      if (bus.oEop !== 1'b0) begin errors++; $display("FAIL reset_eop got=%b want=0", bus.oEop); end
      if (bus.oByte_enable !== 8'h00) begin errors++; $display("FAIL reset_be got=%h want=00", bus.oByte_enable); end
      if (bus.oPacket !== 64'h0) begin errors++; $display("FAIL reset_packet got=%h want=0", bus.oPacket); end
      if (bus.oReady !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", bus.oReady); end
`ifdef BYTE_STREAM_PACKER_LEN_EN
      checks++;
      if (bus.oLength !== 16'd0) begin errors++; $display("FAIL reset_length got=%0d want=0", bus.oLength); end
`endif
      iReset = 1'b0;
      @(negedge iClk);
      checks++;
      if (bus.oReady !== 1'b1) begin errors++; $display("FAIL ready_rise got=%b want=1", bus.oReady); end
   endtask
   task automatic test_stream25;
      logic [63:0] exp_d;
      q.delete();
      for (int i = 0; i < 25; i++) drive(sb(i), i == 24);
      idle(4);
      checks++;
      if (q.size() != 4) begin errors++; $display("FAIL s25_count got=%0d want=4", q.size()); end
      else for (int k = 0; k < 4; k++) begin
         exp_d = '0;
         for (int j = 0; j < 8; j++) if (8 * k + j < 25) exp_d[8*j +: 8] = sb(8 * k + j);
         checks += 4;
         if (q[k].be !== (k < 3 ? 8'hFF : 8'h01)) begin errors++; $display("FAIL s25_be[%0d] got=%h want=%h", k, q[k].be, (k < 3 ? 8'hFF : 8'h01)); end
         if (q[k].s !== (k == 0)) begin errors++; $display("FAIL s25_sop[%0d] got=%b", k, q[k].s); end
         if (q[k].e !== (k == 3)) begin errors++; $display("FAIL s25_eop[%0d] got=%b", k, q[k].e); end
         if (q[k].d !== exp_d) begin errors++; $display("FAIL s25_data[%0d] got=%h want=%h", k, q[k].d, exp_d); end
      end
   endtask
   task automatic test_full8;
      q.delete();
      for (int i = 0; i < 8; i++) drive(8'(i), i == 7);
      idle(6);
      checks++;
      if (q.size() != 1) begin errors++; $display("FAIL full8_count got=%0d want=1", q.size()); end
      else begin
         checks += 4;
         if (q[0].d !== 64'h0706050403020100) begin errors++; $display("FAIL full8_data got=%h want=0706050403020100", q[0].d); end
         if (q[0].be !== 8'hFF) begin errors++; $display("FAIL full8_be got=%h want=ff", q[0].be); end
         if (q[0].s !== 1'b1) begin errors++; $display("FAIL full8_sop got=%b want=1", q[0].s); end
         if (q[0].e !== 1'b1) begin errors++; $display("FAIL full8_eop got=%b want=1", q[0].e); end
      end
   endtask
   task automatic test_back_to_back;
      logic [63:0] ed[3];
      logic [7:0] eb[3];
      logic es[3], ee[3];
      ed = '{64'hA5, 64'h1716151413121110, 64'h1918};
      eb = '{8'h01, 8'hFF, 8'h03};
      es = '{1'b1, 1'b1, 1'b0};
      ee = '{1'b1, 1'b0, 1'b1};
      q.delete();
      drive(8'hA5, 1'b1);
      for (int i = 0; i < 10; i++) drive(8'(8'h10 + i), i == 9);
      idle(4);
      checks++;
      if (q.size() != 3) begin errors++; $display("FAIL b2b_count got=%0d want=3", q.size()); end
      else for (int k = 0; k < 3; k++) begin
         checks += 4;
         if (q[k].d !== ed[k]) begin errors++; $display("FAIL b2b_data[%0d] got=%h want=%h", k, q[k].d, ed[k]); end
         if (q[k].be !== eb[k]) begin errors++; $display("FAIL b2b_be[%0d] got=%h want=%h", k, q[k].be, eb[k]); end
         if (q[k].s !== es[k]) begin errors++; $display("FAIL b2b_sop[%0d] got=%b want=%b", k, q[k].s, es[k]); end
         if (q[k].e !== ee[k]) begin errors++; $display("FAIL b2b_eop[%0d] got=%b want=%b", k, q[k].e, ee[k]); end
      end
   endtask
   task automatic test_gaps;
      int t0, t1;
      t0 = 0;
      t1 = 0;
      q.delete();
      for (int i = 0; i < 12; i++) begin
         drive(8'(8'h40 + i), i == 11);
         if (i == 7) t0 = last_cyc;
         if (i == 11) t1 = last_cyc;
         idle(1);
      end
      idle(3);
      checks++;
      if (q.size() != 2) begin errors++; $display("FAIL gaps_count got=%0d want=2", q.size()); end
      else begin
         checks += 8;
         if (q[0].be !== 8'hFF || q[0].s !== 1'b1 || q[0].e !== 1'b0) begin errors++; $display("FAIL gaps_beat0 be=%h sop=%b eop=%b want ff/1/0", q[0].be, q[0].s, q[0].e); end
         if (q[1].be !== 8'h0F || q[1].s !== 1'b0 || q[1].e !== 1'b1) begin errors++; $display("FAIL gaps_beat1 be=%h sop=%b eop=%b want 0f/0/1", q[1].be, q[1].s, q[1].e); end
         if (q[0].d !== 64'h4746454443424140) begin errors++; $display("FAIL gaps_data0 got=%h want=4746454443424140", q[0].d); end
         if (q[1].d !== 64'h4B4A4948) begin errors++; $display("FAIL gaps_data1 got=%h want=4b4a4948", q[1].d); end
         if (q[0].c != t0 + 1) begin errors++; $display("FAIL gaps_lat0 got=%0d want=%0d", q[0].c, t0 + 1); end
         if (q[1].c != t1 + 1) begin errors++; $display("FAIL gaps_lat1 got=%0d want=%0d", q[1].c, t1 + 1); end
         if (q[1].c - q[0].c != 8) begin errors++; $display("FAIL gaps_spacing got=%0d want=8", q[1].c - q[0].c); end
         if (q[0].len !== q[0].len) begin errors++; end
      end
   endtask
   task automatic test_reset_mid;
      q.delete();
      for (int i = 0; i < 5; i++) drive(8'(8'h20 + i), 1'b0);
      @(negedge iClk);
      bus.iValid = 1'b0;
      iReset = 1'b1;
      @(negedge iClk);
      checks += 2;
      if (bus.oReady !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b want=0", bus.oReady); end
      if (bus.oValid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", bus.oValid); end
      iReset = 1'b0;
      idle(1);
      drive(8'h31, 1'b0);
      drive(8'h32, 1'b0);
      drive(8'h33, 1'b1);
      idle(4);
      checks++;
      if (q.size() != 1) begin errors++; $display("FAIL midrst_count got=%0d want=1", q.size()); end
      else begin
         checks += 4;
         if (q[0].be !== 8'h07) begin errors++; $display("FAIL midrst_be got=%h want=07", q[0].be); end
         if (q[0].d !== 64'h333231) begin errors++; $display("FAIL midrst_data got=%h want=333231", q[0].d); end
         if (q[0].s !== 1'b1) begin errors++; $display("FAIL midrst_sop got=%b want=1", q[0].s); end
         if (q[0].e !== 1'b1) begin errors++; $display("FAIL midrst_eop got=%b want=1", q[0].e); end
      end
   endtask
`ifdef BYTE_STREAM_PACKER_LEN_EN
   task automatic test_length;
      q.delete();
      for (int i = 0; i < 25; i++) drive(sb(i), i == 24);
      drive(8'h77, 1'b1);
      idle(4);
      checks++;
      if (q.size() != 5) begin errors++; $display("FAIL len_count got=%0d want=5", q.size()); end
      else begin
         checks += 2;
         if (q[3].len !== 16'd25) begin errors++; $display("FAIL len_25 got=%0d want=25", q[3].len); end
         if (q[4].len !== 16'd1) begin errors++; $display("FAIL len_1 got=%0d want=1", q[4].len); end
      end
   endtask
`endif
   initial begin
      bus.iValid = 1'b0;
      bus.iByte = 8'h00;
      bus.iLast = 1'b0;
      test_reset;
      test_stream25;
      test_full8;
      test_back_to_back;
      test_gaps;
      test_reset_mid;
`ifdef BYTE_STREAM_PACKER_LEN_EN
      test_length;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
